// File: rtl/muls_pkg.sv
// Shared types and elaboration helpers for the iterative multiplier.
package muls_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int steps_of(input int width, input int unroll);
        return width / unroll;
    endfunction

    function automatic int cnt_width(input int width, input int unroll);
        return $clog2(steps_of(width, unroll) + 1);
    endfunction

    function automatic bit params_ok(input int width, input int unroll);
        return (width >= 4) && (unroll >= 1) && (width % unroll == 0) &&
               (unroll == 1 || unroll == 2 || unroll == 4 || unroll == width);
    endfunction

endpackage

// File: rtl/muls_pp_step.sv
// One cycle's worth of partial-product rows, summed into a single signed addend.
module muls_pp_step
    import muls_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int UNROLL = 1
) (
    input  logic [2*WIDTH-1:0] i_mcand,
    input  logic [UNROLL-1:0]  i_bits,
    input  logic               i_last,
    input  logic               i_b_signed,
    output logic [2*WIDTH-1:0] o_addend
);

    logic [2*WIDTH-1:0] w_sum;

    // The top multiplier bit of a signed b carries weight -2^(WIDTH-1).
    always_comb begin
        w_sum = '0;
        for (int j = 0; j < UNROLL; j++) begin
            if (i_bits[j]) begin
                if (i_last && i_b_signed && (j == UNROLL - 1))
                    w_sum = w_sum - (i_mcand << j);
                else
                    w_sum = w_sum + (i_mcand << j);
            end
        end
    end

    assign o_addend = w_sum;

endmodule

// File: rtl/muls_iter.sv
// Iterative signed/unsigned multiplier, UNROLL multiplier bits retired per cycle.
module muls_iter
    import muls_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int UNROLL = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               a_signed,
    input  logic               b_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] y
);

    localparam int STEPS = steps_of(WIDTH, UNROLL);
    localparam int CW    = cnt_width(WIDTH, UNROLL);

    if (!params_ok(WIDTH, UNROLL)) begin : g_bad_params
        $error("muls_iter: illegal WIDTH/UNROLL combination");
    end

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_mcand, r_acc, w_addend, w_a_ext;
    logic [WIDTH-1:0]   r_b, w_b_nxt;
    logic               r_b_signed;
    logic               w_last, w_accept;

    assign w_last   = (r_cnt == CW'(STEPS - 1));
    assign w_accept = in_valid && in_ready;
    assign w_a_ext  = a_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign y        = r_acc;

    // Multiplier bits are consumed from the LSB end; a single-step config has nothing left to shift.
    if (UNROLL < WIDTH) begin : g_bshift
        assign w_b_nxt = {{UNROLL{1'b0}}, r_b[WIDTH-1:UNROLL]};
    end else begin : g_bnoshift
        assign w_b_nxt = '0;
    end

    muls_pp_step #(
        .WIDTH (WIDTH),
        .UNROLL(UNROLL)
    ) u_step (
        .i_mcand   (r_mcand),
        .i_bits    (r_b[UNROLL-1:0]),
        .i_last    (w_last),
        .i_b_signed(r_b_signed),
        .o_addend  (w_addend)
    );

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = BUSY;
            end
            BUSY: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_b        <= '0;
            r_b_signed <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_mcand    <= w_a_ext;
                r_b        <= b;
                r_b_signed <= b_signed;
                r_acc      <= '0;
                r_cnt      <= '0;
            end else if (r_state == BUSY) begin
                r_acc   <= r_acc + w_addend;
                r_cnt   <= r_cnt + 1'b1;
                r_mcand <= r_mcand << UNROLL;
                r_b     <= w_b_nxt;
            end
        end
    end

endmodule

// File: doc/muls_iter.md
Name: muls_iter

Overview:
- Iterative, parametrised signed/unsigned integer multiplier; successor to the team's fixed 16x16 combinational signed multiplier.
- Retires UNROLL multiplier bits per cycle into a 2*WIDTH accumulator.
- Operand signedness is selected per transaction.
- Uses valid/ready handshakes on input and output, so it drops into datapaths where a full combinational array is too large or too slow.

Parameters:
- WIDTH, 16, operand width in bits; must be at least 4.
- UNROLL, 1, multiplier bits consumed per cycle; must divide WIDTH. Legal values are 1, 2, 4 and WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- a_signed  in  1  1 = treat a as two's complement, 0 = unsigned.
- b_signed  in  1  1 = treat b as two's complement, 0 = unsigned.
- out_valid  out  1  product y is valid.
- out_ready  in  1  consumer accepts y.
- y  out  2*WIDTH  product.

Behaviour:
- Reset:
  - The block is held in IDLE while rst is high.
  - in_ready=1, out_valid=0, y=0, step counter=0, accumulator=0.
- States:
  - IDLE: in_ready=1. in_valid&in_ready moves to BUSY. The operands and both sign flags are captured at that edge.
  - BUSY: in_ready=0. Each cycle adds UNROLL partial-product rows into the accumulator and increments the counter. After STEPS=WIDTH/UNROLL cycles the state moves to DONE.
  - DONE: out_valid=1 and y is stable. out_valid&out_ready returns the block to IDLE on the next edge.
  - Input is not accepted in the same cycle as output release. in_ready rises the cycle after the handshake, so the throughput is one product per STEPS+2 cycles.
- Latency: out_valid rises exactly STEPS cycles after the accepting edge.
- Arithmetic:
  - y equals the exact product of the interpreted operands, modulo 2^(2*WIDTH).
  - Every signedness combination fits exactly in 2*WIDTH bits, so there is no overflow.
  - Each operand is extended to WIDTH+1 bits: sign-extended when its flag is 1, zero-extended when 0.
  - Rows for multiplier bits 0..WIDTH-1 are added as a shifted, sign-extended multiplicand.
  - When b_signed=1 and b[WIDTH-1]=1, the final row is subtracted rather than added (Baugh-Wooley / two's-complement MSB weight -2^(WIDTH-1)).
- Output stability: y and out_valid hold while out_valid=1 and out_ready=0. Input a/b changes while BUSY or DONE have no effect.
- in_valid while not in IDLE is ignored. The upstream holds it per the handshake rules.
- Reset mid-operation: the transaction in flight is discarded and no out_valid is produced. The block returns to IDLE, with in_ready=1 in the cycle after rst falls.
- Zero operand: the full STEPS latency still applies. There is no early termination.

Decomposition:
- Shared package muls_pkg holds:
  - The state enum: IDLE, BUSY, DONE.
  - A function computing STEPS and the counter width, $clog2(STEPS+1).
  - A parameter-legality check function, used by an elaboration-time assertion.
- One sub-module, muls_pp_step (combinational). Given the extended multiplicand, UNROLL multiplier bits, a "last-step" flag and the b_signed flag, it returns the shifted signed addend for one cycle.
- The top level holds the FSM, counter, operand/accumulator registers and handshakes.

Test Plan:
1. WIDTH=16, UNROLL=1, signed×signed, a=0xFFFF, b=0xFFFF → y=0x00000001, out_valid exactly 16 cycles after accept.
2. Signed×signed, a=0x8000, b=0x8000 → y=0x40000000. Unsigned×unsigned, a=0xFFFF, b=0xFFFF → y=0xFFFE0001.
3. Mixed: a_signed=1, b_signed=0, a=0xFFFE, b=0xFFFF → y=0xFFFE0002 (−131070). Swap the flags with a=0xFFFF, b=0xFFFE → y=0xFFFE0002.
4. Backpressure:
   - Hold out_ready=0 for 5 cycles after out_valid; y must stay constant and in_ready must stay 0.
   - Then raise out_ready; in_ready must be 1 on the following cycle.
5. Reset mid-op: assert rst on the 7th BUSY cycle. Required: out_valid never asserts, in_ready=1 after rst falls, and the next op (3×5 unsigned) gives y=15.
6. WIDTH=16, UNROLL=4: 1000 random operand and signedness-flag combinations checked against a reference model, each with latency exactly 4 cycles. Repeat for WIDTH=8, UNROLL=8 with latency 1.
